// File: rtl/weight_sram_pkg.sv
// Shared types and default geometry for the weight SRAM controller.
// The request struct describes one macro access: where, what, and whether it writes.
package weight_sram_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 18;

   typedef enum logic {IDLE, CLEAR} wsc_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              we;
   } wsc_req_t;

endpackage

// File: rtl/weight_sram_arb.sv
// Write-priority arbiter between the weight loader and the PE fetch port.
// A waiting read is forced through after STARVE_LIMIT consecutive write grants.
module weight_sram_arb
#(
   parameter int STARVE_LIMIT = 4
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic wr_valid,
   input  logic rd_valid,
   output logic wr_grant,
   output logic rd_grant
);

   import weight_sram_pkg::*;

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;

   always_comb begin
      rd_grant = 1'b0;
      wr_grant = 1'b0;
      if (enable) begin
         rd_grant = rd_valid & (~wr_valid | (starve_cnt == LIMIT));
         wr_grant = wr_valid & ~rd_grant;
      end
   end

   // Counts writes that overtook a pending read; saturates so the read wins next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!rd_valid || rd_grant) begin
         starve_cnt <= '0;
      end else if (wr_grant && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/weight_sram_ctrl.sv
// Weight SRAM macro controller: arbitrates loader writes against PE reads,
// runs a bulk clear over a wrapping address range, and returns reads one cycle later.
module weight_sram_ctrl
#(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 18,
   parameter int STARVE_LIMIT = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_rvalid,
   output logic [DATA_W-1:0] rd_rdata,
   input  logic              clr_start,
   input  logic [ADDR_W-1:0] clr_base,
   input  logic [ADDR_W:0]   clr_len,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              sram_cs,
   output logic              sram_oe,
   output logic              sram_web,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_di,
   input  logic [DATA_W-1:0] sram_do
);

   import weight_sram_pkg::*;

   wsc_state_e        state;
   wsc_state_e        state_nxt;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W:0]   clr_left;
   logic              clr_write;
   logic              arb_en;
   logic              wr_fire;
   logic              rd_fire;
   logic [DATA_W-1:0] rdata_hold;

   assign arb_en = (state == IDLE);

   weight_sram_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (arb_en),
      .wr_valid (wr_valid),
      .rd_valid (rd_valid),
      .wr_grant (wr_fire),
      .rd_grant (rd_fire)
   );

   assign wr_ready = wr_fire;
   assign rd_ready = rd_fire;
   assign clr_busy = (state == CLEAR);
   assign sram_oe  = rd_rvalid;
   assign rd_rdata = rd_rvalid ? sram_do : rdata_hold;

   // The final clear write and the return to IDLE share one cycle; an empty clear exits at once.
   always_comb begin
      state_nxt = state;
      clr_done  = 1'b0;
      clr_write = 1'b0;
      case (state)
         IDLE: begin
            if (clr_start) begin
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            clr_write = (clr_left != '0);
            if (clr_left <= (ADDR_W+1)'(1)) begin
               state_nxt = IDLE;
               clr_done  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sram_cs  = 1'b0;
      sram_web = 1'b1;
      sram_a   = '0;
      sram_di  = '0;
      if (clr_write) begin
         sram_cs  = 1'b1;
         sram_web = 1'b0;
         sram_a   = clr_addr;
      end else if (wr_fire) begin
         sram_cs  = 1'b1;
         sram_web = 1'b0;
         sram_a   = wr_addr;
         sram_di  = wr_data;
      end else if (rd_fire) begin
         sram_cs  = 1'b1;
         sram_a   = rd_addr;
      end
   end

   // Clear range is captured at start; the address counter wraps naturally at the array end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         clr_addr   <= '0;
         clr_left   <= '0;
         rd_rvalid  <= 1'b0;
         rdata_hold <= '0;
      end else begin
         state     <= state_nxt;
         rd_rvalid <= rd_fire;
         if (rd_rvalid) begin
            rdata_hold <= sram_do;
         end
         if ((state == IDLE) && clr_start) begin
            clr_addr <= clr_base;
            clr_left <= clr_len;
         end else if (clr_write) begin
            clr_addr <= clr_addr + ADDR_W'(1);
            clr_left <= clr_left - (ADDR_W+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Self-checking bench for weight_sram_ctrl with a registered-output SRAM macro model
// and a word-array scoreboard that follows every accepted write and clear.
module tb_weight_sram_ctrl;

   localparam int AW    = 14;
   localparam int DW    = 18;
   localparam int LIMIT = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_rvalid;
   logic [AW-1:0] wr_addr, rd_addr, clr_base, sram_a;
   logic [DW-1:0] wr_data, rd_rdata, sram_di, sram_do;
   logic          clr_start, clr_busy, clr_done;
   logic [AW:0]   clr_len;
   logic          sram_cs, sram_oe, sram_web;

   int checkCnt = 0;
   int passCnt  = 0;

   logic [DW-1:0] sramMem [DEPTH];
   logic [DW-1:0] refMem  [DEPTH];
   logic [DW-1:0] doReg = '0;
   logic [DW-1:0] expData;

   weight_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
      .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
      .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
   );

   always #5 clk = ~clk;

   // Macro model: synchronous write, registered read data.
   always @(posedge clk) begin
      if (sram_cs) begin
         if (!sram_web) sramMem[sram_a] <= sram_di;
         else           doReg <= sramMem[sram_a];
      end
   end
   assign sram_do = doReg;

   task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic rv, input logic [AW-1:0] ra);
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      rd_valid = rv; rd_addr = ra;
   endtask

   task automatic test_reset;
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      clr_start = 1'b0; clr_base = '0; clr_len = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkCnt++; if ({wr_ready, rd_ready, rd_rvalid, clr_busy, clr_done, sram_cs, sram_oe} !== 7'b0)
         $display("[TB] FAIL reset_flags: got %b want 0000000", {wr_ready, rd_ready, rd_rvalid, clr_busy, clr_done, sram_cs, sram_oe});
      else passCnt++;
      checkCnt++; if (sram_web !== 1'b1) $display("[TB] FAIL reset_web: got %b want 1", sram_web); else passCnt++;
      checkCnt++; if (rd_rdata !== '0) $display("[TB] FAIL reset_rdata: got %h want 0", rd_rdata); else passCnt++;
      checkCnt++; if ({sram_a, sram_di} !== '0) $display("[TB] FAIL reset_addr_data: got %h/%h want 0/0", sram_a, sram_di); else passCnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write_read;
      @(negedge clk);
      applyStimulus(1'b1, 14'h0005, 18'h2ABCD, 1'b0, '0);
      #1;
      checkCnt++; if ({wr_ready, rd_ready} !== 2'b10) $display("[TB] FAIL wr_grant: got %b want 10", {wr_ready, rd_ready}); else passCnt++;
      checkCnt++; if ({sram_cs, sram_web, sram_a, sram_di} !== {1'b1, 1'b0, 14'h0005, 18'h2ABCD})
         $display("[TB] FAIL wr_pins: got cs=%b web=%b a=%h di=%h want 1/0/0005/2abcd", sram_cs, sram_web, sram_a, sram_di);
      else passCnt++;
      refMem[5] = 18'h2ABCD;
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b1, 14'h0005);
      #1;
      checkCnt++; if ({rd_ready, sram_cs, sram_web, sram_a} !== {1'b1, 1'b1, 1'b1, 14'h0005})
         $display("[TB] FAIL rd_pins: got rdy=%b cs=%b web=%b a=%h want 1/1/1/0005", rd_ready, sram_cs, sram_web, sram_a);
      else passCnt++;
      checkCnt++; if (rd_rvalid !== 1'b0) $display("[TB] FAIL rd_early: got %b want 0", rd_rvalid); else passCnt++;
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      #1;
      checkCnt++; if ({rd_rvalid, sram_oe, sram_cs} !== 3'b110) $display("[TB] FAIL rd_return_flags: got %b want 110", {rd_rvalid, sram_oe, sram_cs}); else passCnt++;
      checkCnt++; if (rd_rdata !== 18'h2ABCD) $display("[TB] FAIL rd_return_data: got %h want 2abcd", rd_rdata); else passCnt++;
      @(negedge clk);
      #1;
      checkCnt++; if ({rd_rvalid, rd_rdata} !== {1'b0, 18'h2ABCD}) $display("[TB] FAIL rd_hold: got %b/%h want 0/2abcd", rd_rvalid, rd_rdata); else passCnt++;
   endtask

   task automatic test_starvation;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      logic          expR, prevRead;
      int            sinceRead, maxWait;
      prevRead = 1'b0; sinceRead = 0; maxWait = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         wa = AW'($urandom_range(0, DEPTH-1));
         ra = AW'($urandom_range(0, DEPTH-1));
         wd = DW'($urandom);
         applyStimulus(1'b1, wa, wd, 1'b1, ra);
         #1;
         if (prevRead) begin
            checkCnt++; if ({rd_rvalid, rd_rdata} !== {1'b1, expData})
               $display("[TB] FAIL starve_rdata[%0d]: got %b/%h want 1/%h", i, rd_rvalid, rd_rdata, expData);
            else passCnt++;
         end
         expR = ((i % (LIMIT + 1)) == LIMIT);
         checkCnt++; if ({wr_ready, rd_ready} !== {~expR, expR})
            $display("[TB] FAIL starve_grant[%0d]: got %b want %b", i, {wr_ready, rd_ready}, {~expR, expR});
         else passCnt++;
         if (rd_ready) sinceRead = 0; else sinceRead++;
         if (sinceRead > maxWait) maxWait = sinceRead;
         if (expR) expData = refMem[ra]; else refMem[wa] = wd;
         prevRead = expR;
      end
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      #1;
      checkCnt++; if (maxWait > LIMIT) $display("[TB] FAIL starve_wait: got %0d want <= %0d", maxWait, LIMIT); else passCnt++;
   endtask

   task automatic test_clear_wrap;
      logic [AW-1:0] ra, ea;
      int            doneCnt, bad;
      doneCnt = 0;
      @(negedge clk);
      ra = AW'($urandom_range(0, DEPTH-1));
      applyStimulus(1'b0, '0, '0, 1'b1, ra);
      clr_start = 1'b1; clr_base = 14'h3FFE; clr_len = 15'd4;
      #1;
      checkCnt++; if ({rd_ready, clr_busy} !== 2'b10) $display("[TB] FAIL clr_start_cycle: got %b want 10", {rd_ready, clr_busy}); else passCnt++;
      expData = refMem[ra];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         clr_start = 1'b0;
         applyStimulus(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom));
         #1;
         if (i == 0) begin
            checkCnt++; if ({rd_rvalid, rd_rdata} !== {1'b1, expData})
               $display("[TB] FAIL clr_prior_read: got %b/%h want 1/%h", rd_rvalid, rd_rdata, expData);
            else passCnt++;
         end
         ea = 14'h3FFE;
         ea = ea + AW'(i);
         checkCnt++; if ({clr_busy, wr_ready, rd_ready} !== 3'b100)
            $display("[TB] FAIL clr_ready[%0d]: got %b want 100", i, {clr_busy, wr_ready, rd_ready});
         else passCnt++;
         checkCnt++; if ({sram_cs, sram_web, sram_a, sram_di} !== {1'b1, 1'b0, ea, 18'h0})
            $display("[TB] FAIL clr_pins[%0d]: got cs=%b web=%b a=%h di=%h want 1/0/%h/0", i, sram_cs, sram_web, sram_a, sram_di, ea);
         else passCnt++;
         checkCnt++; if (clr_done !== (i == 3)) $display("[TB] FAIL clr_done[%0d]: got %b want %b", i, clr_done, (i == 3)); else passCnt++;
         if (clr_done) doneCnt++;
         refMem[ea] = '0;
      end
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      #1;
      if (clr_done) doneCnt++;
      checkCnt++; if ({clr_busy, sram_cs} !== 2'b00) $display("[TB] FAIL clr_exit: got %b want 00", {clr_busy, sram_cs}); else passCnt++;
      checkCnt++; if (doneCnt != 1) $display("[TB] FAIL clr_done_count: got %0d want 1", doneCnt); else passCnt++;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         ea = 14'h3FFE;
         ea = ea + AW'(i);
         if (sramMem[ea] !== '0) bad++;
      end
      checkCnt++; if (bad != 0) $display("[TB] FAIL clr_mem: got %0d nonzero words want 0", bad); else passCnt++;
   endtask

   task automatic test_clear_zero;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      @(negedge clk);
      wa = AW'($urandom); wd = DW'($urandom);
      applyStimulus(1'b1, wa, wd, 1'b0, '0);
      clr_start = 1'b1; clr_base = AW'($urandom); clr_len = '0;
      #1;
      checkCnt++; if ({wr_ready, sram_cs, sram_web, sram_a, sram_di} !== {1'b1, 1'b1, 1'b0, wa, wd})
         $display("[TB] FAIL clr0_same_cycle_write: got rdy=%b cs=%b a=%h di=%h want 1/1/%h/%h", wr_ready, sram_cs, sram_a, sram_di, wa, wd);
      else passCnt++;
      refMem[wa] = wd;
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      clr_start = 1'b1; clr_len = 15'd5;
      #1;
      checkCnt++; if ({clr_busy, clr_done, sram_cs} !== 3'b110) $display("[TB] FAIL clr0_done: got %b want 110", {clr_busy, clr_done, sram_cs}); else passCnt++;
      @(negedge clk);
      clr_start = 1'b0;
      #1;
      checkCnt++; if ({clr_busy, clr_done, sram_cs} !== 3'b000) $display("[TB] FAIL clr0_after: got %b want 000", {clr_busy, clr_done, sram_cs}); else passCnt++;
      @(negedge clk);
      #1;
      checkCnt++; if ({clr_busy, sram_cs} !== 2'b00) $display("[TB] FAIL clr0_ignored_start: got %b want 00", {clr_busy, sram_cs}); else passCnt++;
   endtask

   task automatic test_reset_mid_clear;
      logic [AW-1:0] base, ea;
      int            bad;
      base = 14'h1000;
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      clr_start = 1'b1; clr_base = base; clr_len = 15'd200;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         clr_start = 1'b0;
      end
      @(negedge clk);
      #1;
      ea = base + AW'(100);
      checkCnt++; if ({sram_cs, sram_a} !== {1'b1, ea}) $display("[TB] FAIL mid_clear_word: got %b/%h want 1/%h", sram_cs, sram_a, ea); else passCnt++;
      rst_n = 1'b0;
      #1;
      checkCnt++; if ({wr_ready, rd_ready, rd_rvalid, clr_busy, clr_done, sram_cs, sram_oe, sram_web} !== 8'b00000001)
         $display("[TB] FAIL abort_flags: got %b want 00000001", {wr_ready, rd_ready, rd_rvalid, clr_busy, clr_done, sram_cs, sram_oe, sram_web});
      else passCnt++;
      checkCnt++; if ({rd_rdata, sram_a, sram_di} !== '0) $display("[TB] FAIL abort_buses: got %h/%h/%h want 0", rd_rdata, sram_a, sram_di); else passCnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checkCnt++; if ({clr_busy, sram_cs} !== 2'b00) $display("[TB] FAIL abort_no_resume: got %b want 00", {clr_busy, sram_cs}); else passCnt++;
      for (int i = 0; i < 100; i++) begin
         ea = base + AW'(i);
         refMem[ea] = '0;
      end
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         ea = base + AW'(i);
         if (sramMem[ea] !== refMem[ea]) bad++;
      end
      checkCnt++; if (bad != 0) $display("[TB] FAIL abort_mem: got %0d wrong words want 0", bad); else passCnt++;
   endtask

   task automatic test_random_traffic;
      logic          wv, rv, expW, expR, prevRead;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      int            waitW;
      prevRead = 1'b0; waitW = 0;
      for (int i = 0; i <= 400; i++) begin
         @(negedge clk);
         wv = (i < 400) && ($urandom_range(0, 99) < 60);
         rv = (i < 400) && ($urandom_range(0, 99) < 55);
         wa = 14'h0200 + AW'($urandom_range(0, 15));
         ra = 14'h0200 + AW'($urandom_range(0, 15));
         wd = DW'($urandom);
         applyStimulus(wv, wa, wd, rv, ra);
         #1;
         checkCnt++; if ({rd_rvalid, (prevRead ? rd_rdata : expData)} !== {prevRead, expData})
            $display("[TB] FAIL rnd_read[%0d]: got %b/%h want %b/%h", i, rd_rvalid, rd_rdata, prevRead, expData);
         else passCnt++;
         expR = rv && (!wv || (waitW == LIMIT));
         expW = wv && !expR;
         checkCnt++; if ({wr_ready, rd_ready} !== {expW, expR})
            $display("[TB] FAIL rnd_grant[%0d]: got %b want %b", i, {wr_ready, rd_ready}, {expW, expR});
         else passCnt++;
         if (!expW && !expR) begin
            checkCnt++; if (sram_cs !== 1'b0) $display("[TB] FAIL rnd_idle_cs[%0d]: got %b want 0", i, sram_cs); else passCnt++;
         end else begin
            checkCnt++; if ({sram_cs, sram_web, sram_a} !== {1'b1, expR, (expR ? ra : wa)})
               $display("[TB] FAIL rnd_pins[%0d]: got cs=%b web=%b a=%h want 1/%b/%h", i, sram_cs, sram_web, sram_a, expR, (expR ? ra : wa));
            else passCnt++;
         end
         if (expW) refMem[wa] = wd;
         if (expR) expData = refMem[ra];
         if (!rv || expR) waitW = 0;
         else if (expW && waitW < LIMIT) waitW++;
         prevRead = expR;
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         sramMem[i] = DW'(i) | 18'h20000;
         refMem[i]  = DW'(i) | 18'h20000;
      end
      expData = '0;
      test_reset();
      test_write_read();
      test_starvation();
      test_clear_wrap();
      test_clear_zero();
      test_reset_mid_clear();
      test_random_traffic();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
